// File: rtl/layer_sequencer.sv
// layer_sequencer: walks a programmable layer table, resetting, launching and granting the shared bus to one engine per layer
module layer_sequencer #(
    parameter int NUM_ENGINES    = 4,
    parameter int MAX_LAYERS     = 8,
    parameter int ADDR_WIDTH     = 8,
    parameter int ENG_ID_WIDTH   = 2,
    parameter int TIMEOUT_CYCLES = 4096,
    localparam int LW = $clog2(MAX_LAYERS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cfg_we,
    input  logic [LW-1:0]           cfg_idx,
    input  logic [ENG_ID_WIDTH-1:0] cfg_engine,
    input  logic [ADDR_WIDTH-1:0]   cfg_in_addr,
    input  logic [ADDR_WIDTH-1:0]   cfg_out_addr,
    input  logic [LW:0]             cfg_num_layers,
    input  logic                    go,
    output logic                    busy,
    output logic                    done,
    output logic                    error,
    output logic [LW-1:0]           cur_layer,
    output logic [NUM_ENGINES-1:0]  eng_rst,
    output logic [NUM_ENGINES-1:0]  eng_start,
    input  logic [NUM_ENGINES-1:0]  eng_done,
    output logic [ADDR_WIDTH-1:0]   eng_input_addr,
    output logic [ADDR_WIDTH-1:0]   eng_output_addr,
    output logic [NUM_ENGINES-1:0]  bus_grant
);
    localparam int WW = $clog2(TIMEOUT_CYCLES + 2);

    typedef enum logic [2:0] {IDLE, CLEAR, LAUNCH, WAIT, ADVANCE} state_t;
    state_t state, next;

    logic [ENG_ID_WIDTH-1:0] tbl_eng [MAX_LAYERS];
    logic [ADDR_WIDTH-1:0]   tbl_in  [MAX_LAYERS];
    logic [ADDR_WIDTH-1:0]   tbl_out [MAX_LAYERS];
    logic [LW:0]             n_layers, n_req;
    logic [ENG_ID_WIDTH-1:0] act_id, cur_id;
    logic [ADDR_WIDTH-1:0]   in_q, out_q;
    logic [WW-1:0]           wdog;
    logic [NUM_ENGINES-1:0]  sel;
    logic                    hit, timeout, bad_id, last;

    // In CLEAR the entry is read straight from the table so a same-cycle write is seen; afterwards the latched copy is used
    assign n_req   = cfg_num_layers > (LW+1)'(MAX_LAYERS) ? (LW+1)'(MAX_LAYERS) : cfg_num_layers;
    assign cur_id  = state == CLEAR ? tbl_eng[cur_layer] : act_id;
    assign sel     = NUM_ENGINES'(1) << cur_id;
    assign bad_id  = int'(cur_id) >= NUM_ENGINES;
    assign hit     = |(eng_done & sel);
    assign timeout = TIMEOUT_CYCLES != 0 && state == WAIT && !hit && wdog == WW'(TIMEOUT_CYCLES - 1);
    assign last    = {1'b0, cur_layer} == n_layers - (LW+1)'(1);
    assign busy    = state != IDLE;

    // Layer table; contents survive reset and only change while idle
    always_ff @(posedge clk)
        if (cfg_we && state == IDLE) begin
            tbl_eng[cfg_idx] <= cfg_engine;
            tbl_in[cfg_idx]  <= cfg_in_addr;
            tbl_out[cfg_idx] <= cfg_out_addr;
        end

    // State register
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else     state <= next;

    // Next-state logic
    always_comb begin
        next = state;
        case (state)
            IDLE:    next = go && n_req != '0 ? CLEAR : IDLE;
            CLEAR:   next = bad_id ? IDLE : LAUNCH;
            LAUNCH:  next = WAIT;
            WAIT:    next = hit ? ADVANCE : timeout ? IDLE : WAIT;
            ADVANCE: next = last ? IDLE : CLEAR;
            default: next = IDLE;
        endcase
    end

    // Engine strobes and bus grant; a watchdog abort resets the stuck engine and drops its grant in the same cycle
    always_comb begin
        eng_rst         = state == CLEAR || timeout ? sel : '0;
        eng_start       = state == LAUNCH ? sel : '0;
        bus_grant       = state == CLEAR || state == LAUNCH || (state == WAIT && !timeout) ? sel : '0;
        eng_input_addr  = state == CLEAR ? tbl_in[cur_layer] : in_q;
        eng_output_addr = state == CLEAR ? tbl_out[cur_layer] : out_q;
    end

    // Sequence bookkeeping: status flags, layer index, latched entry and watchdog
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            done      <= 1'b0;
            error     <= 1'b0;
            cur_layer <= '0;
            n_layers  <= '0;
            act_id    <= '0;
            in_q      <= '0;
            out_q     <= '0;
            wdog      <= '0;
        end else begin
            if (state == IDLE && go) begin
                done      <= n_req == '0;
                error     <= 1'b0;
                cur_layer <= '0;
                n_layers  <= n_req;
            end
            if (state == CLEAR) begin
                act_id <= tbl_eng[cur_layer];
                in_q   <= tbl_in[cur_layer];
                out_q  <= tbl_out[cur_layer];
                error  <= bad_id;
            end
            if (state == LAUNCH) wdog <= '0;
            if (state == WAIT) wdog <= wdog + WW'(1);
            if (timeout) error <= 1'b1;
            if (state == ADVANCE) begin
                if (last) done <= 1'b1;
                else      cur_layer <= cur_layer + LW'(1);
            end
        end
endmodule

// File: tb/tb_layer_sequencer.sv
// tb_layer_sequencer: directed scenarios with a start-event scoreboard against a behavioural engine model
module tb_layer_sequencer;
    logic       clk = 1'b0, rst = 1'b1;
    logic       cfg_we = 1'b0, go = 1'b0;
    logic [2:0] cfg_idx = '0;
    logic [1:0] cfg_engine = '0;
    logic [7:0] cfg_in_addr = '0, cfg_out_addr = '0;
    logic [3:0] cfg_num_layers = '0;
    logic       busy, done, error;
    logic [2:0] cur_layer, eng_rst, eng_start, eng_done, bus_grant;
    logic [7:0] eng_input_addr, eng_output_addr;

    logic [2:0]  done_r, force_done = '0;
    int          cnt [3];
    int          dly = 10;
    int          n_assert = 0, n_fail = 0, rst1_cnt = 0;
    logic [21:0] sb [$];
    logic [21:0] e;

    layer_sequencer #(.NUM_ENGINES(3), .MAX_LAYERS(8), .ADDR_WIDTH(8), .ENG_ID_WIDTH(2), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_engine(cfg_engine),
        .cfg_in_addr(cfg_in_addr), .cfg_out_addr(cfg_out_addr), .cfg_num_layers(cfg_num_layers),
        .go(go), .busy(busy), .done(done), .error(error), .cur_layer(cur_layer),
        .eng_rst(eng_rst), .eng_start(eng_start), .eng_done(eng_done),
        .eng_input_addr(eng_input_addr), .eng_output_addr(eng_output_addr), .bus_grant(bus_grant)
    );

    always #5 clk = ~clk;

    assign eng_done = done_r | force_done;

    // Engine model: done rises dly cycles after start (never when dly is 0) and holds until engine reset
    always @(posedge clk or posedge rst)
        for (int i = 0; i < 3; i++)
            if (rst || eng_rst[i]) begin
                done_r[i] <= 1'b0;
                cnt[i]    <= 0;
            end else if (eng_start[i]) cnt[i] <= dly;
            else if (cnt[i] == 1) begin
                done_r[i] <= 1'b1;
                cnt[i]    <= 0;
            end else if (cnt[i] > 1) cnt[i] <= cnt[i] - 1;

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [21:0] ex(logic [2:0] oh, logic [7:0] i, logic [7:0] o);
        return {oh, oh, i, o};
    endfunction

    // Scoreboard: every start pulse must match the next expected {grant, start, in, out}
    always @(negedge clk)
        if (!rst && eng_start != '0) begin
            if (sb.size() == 0) check("unexpected_start", 32'(eng_start), 32'd0);
            else begin
                e = sb.pop_front();
                check("start", 32'({bus_grant, eng_start, eng_input_addr, eng_output_addr}), 32'(e));
            end
        end

    always @(negedge clk)
        if (!rst && eng_rst[1]) rst1_cnt++;

    task automatic wr(int idx, int eng, int ia, int oa);
        cfg_we = 1'b1; cfg_idx = 3'(idx); cfg_engine = 2'(eng);
        cfg_in_addr = 8'(ia); cfg_out_addr = 8'(oa);
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic pulse_go();
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
    endtask

    task automatic wait_idle(string tag, int lim);
        int n = 0;
        while (busy && n < lim) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "simulation did not terminate");
    end

    initial begin
        #1;
        check("reset_outputs", 32'({busy, done, error, cur_layer, eng_rst, eng_start, bus_grant}), 32'd0);
        check("reset_addrs", 32'({eng_input_addr, eng_output_addr}), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Two layers on engines 1 then 0
        wr(0, 1, 8'h00, 8'h40);
        wr(1, 0, 8'h40, 8'h80);
        cfg_num_layers = 4'd2;
        sb.push_back(ex(3'b010, 8'h00, 8'h40));
        sb.push_back(ex(3'b001, 8'h40, 8'h80));
        pulse_go();
        check("t1_clear_rst", 32'(eng_rst), 32'b010);
        check("t1_clear_grant", 32'(bus_grant), 32'b010);
        check("t1_clear_addrs", 32'({eng_input_addr, eng_output_addr}), 32'h0040);
        check("t1_busy", 32'(busy), 32'd1);
        wait_idle("t1_idle", 100);
        check("t1_status", 32'({done, error, cur_layer}), 32'b10_001);
        check("t1_grant_off", 32'(bus_grant), 32'd0);

        // Zero layers: done immediately, no engine activity
        cfg_num_layers = 4'd0;
        pulse_go();
        check("t2_status", 32'({busy, done, error}), 32'b010);
        repeat (3) @(negedge clk);
        check("t2_quiet", 32'({eng_rst, bus_grant}), 32'd0);

        // Watchdog: engine 2 never finishes
        dly = 0;
        wr(0, 2, 8'h11, 8'h22);
        cfg_num_layers = 4'd1;
        sb.push_back(ex(3'b100, 8'h11, 8'h22));
        pulse_go();
        repeat (16) @(negedge clk);
        check("t3_wait15_rst", 32'({eng_rst, bus_grant}), 32'b000_100);
        @(negedge clk);
        check("t3_timeout_rst", 32'({eng_rst, bus_grant}), 32'b100_000);
        check("t3_still_busy", 32'(busy), 32'd1);
        @(negedge clk);
        check("t3_abort", 32'({busy, done, error, bus_grant}), 32'b0010_00);
        cfg_num_layers = 4'd0;
        pulse_go();
        check("t3_go_clears_error", 32'({done, error}), 32'b10);

        // Engine id outside the attached range
        wr(0, 3, 8'h33, 8'h44);
        cfg_num_layers = 4'd1;
        pulse_go();
        check("t4_clear", 32'({busy, eng_rst, bus_grant}), 32'b1_000_000);
        @(negedge clk);
        check("t4_error", 32'({busy, done, error}), 32'b001);

        // Same engine three layers in a row with its done level stuck high
        dly = 10;
        force_done = 3'b010;
        wr(0, 1, 8'h01, 8'h02);
        wr(1, 1, 8'h03, 8'h04);
        wr(2, 1, 8'h05, 8'h06);
        cfg_num_layers = 4'd3;
        rst1_cnt = 0;
        sb.push_back(ex(3'b010, 8'h01, 8'h02));
        sb.push_back(ex(3'b010, 8'h03, 8'h04));
        sb.push_back(ex(3'b010, 8'h05, 8'h06));
        pulse_go();
        wait_idle("t5_idle", 100);
        check("t5_rst_count", 32'(rst1_cnt), 32'd3);
        check("t5_status", 32'({done, error, cur_layer}), 32'b10_010);
        force_done = '0;

        // Dropped config/go while busy, then asynchronous reset in WAIT
        wr(0, 1, 8'h00, 8'h40);
        wr(1, 0, 8'h40, 8'h80);
        cfg_num_layers = 4'd2;
        sb.push_back(ex(3'b010, 8'h00, 8'h40));
        pulse_go();
        repeat (4) @(negedge clk);
        cfg_we = 1'b1; cfg_idx = 3'd0; cfg_engine = 2'd2; cfg_in_addr = 8'hEE; cfg_out_addr = 8'hEE;
        go = 1'b1;
        @(negedge clk);
        cfg_we = 1'b0;
        go = 1'b0;
        check("t6_busy_before_rst", 32'(busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("t6_async_rst", 32'({busy, done, error, cur_layer, eng_rst, eng_start, bus_grant}), 32'd0);
        check("t6_async_rst_addrs", 32'({eng_input_addr, eng_output_addr}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        sb.push_back(ex(3'b010, 8'h00, 8'h40));
        sb.push_back(ex(3'b001, 8'h40, 8'h80));
        pulse_go();
        wait_idle("t6_idle", 100);
        check("t6_status", 32'({done, error, cur_layer}), 32'b10_001);
        @(negedge clk);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
